ram_burst_ctrl: RTL and testbench
=================================

# ram_burst_ctrl

Burst command front-end that sits directly upstream of the 128×9 single-port `ram` and is the only driver of its `addr`, `data` and `wr_en` inputs. It accepts one read or write burst command at a time over a valid/ready handshake. For writes, it streams data beats into consecutive RAM addresses. For reads, it returns RAM words in order with a last-beat marker.

## Interface
Parameters:
- `ADDR_W`, 7: RAM address width; 128 words.
- `DATA_W`, 9: RAM word width.
- `LEN_W`, 4: burst length field width; a burst has `cmd_len`+1 beats, 1..16.
- `RD_LAT`, 1: RAM read latency in cycles, from `ram_addr` presented to `ram_q` valid.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. The same net resets the RAM, which reloads its init image.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the block can accept a command; high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: start address.
- `cmd_len` in LEN_W: number of beats minus 1.
- `wdata_valid` in 1: a write beat is offered.
- `wdata_ready` out 1: the block accepts the write beat; high only in WR.
- `wdata` in DATA_W: write beat.
- `rdata_valid` out 1: a read beat is present this cycle. There is no backpressure; the consumer must take it.
- `rdata` out DATA_W: read beat; equals `ram_q`.
- `rdata_last` out 1: marks the final read beat.
- `done` out 1: one-cycle pulse when a burst completes.
- `busy` out 1: high whenever the state is not IDLE.
- `ram_addr` out ADDR_W: connects to RAM `addr`.
- `ram_data` out DATA_W: connects to RAM `data`.
- `ram_wr_en` out 1: connects to RAM `wr_en`.
- `ram_q` in DATA_W: connects to RAM `q`.

## Operation
States: IDLE, WR, RD, RD_DRAIN.
- IDLE: on `cmd_valid & cmd_ready`, latch `addr_cnt`=`cmd_addr` and `beat_cnt`=`cmd_len`, then go to WR if `cmd_write` else RD.
- WR: on each handshake (`wdata_valid & wdata_ready`), register `ram_addr`=`addr_cnt`, `ram_data`=`wdata` and `ram_wr_en`=1 for exactly that next cycle.
  - Increment `addr_cnt`; decrement `beat_cnt`.
  - If `wdata_valid` is low, `ram_wr_en` is 0 the next cycle (a bubble); there is no timeout.
  - When the beat with `beat_cnt`==0 is accepted, go to IDLE and pulse `done` in the same cycle its `ram_wr_en` is high.
- RD: issue one address per cycle: `ram_addr`=`addr_cnt`, `ram_wr_en`=0, increment `addr_cnt`. After issuing the beat with `beat_cnt`==0, go to RD_DRAIN.
- RD_DRAIN: wait until the last issued read returns, then go to IDLE. `done` coincides with `rdata_last`.
- Addresses wrap modulo 2^ADDR_W: 0x7F+1 = 0x00. There is no error on wrap.
- Commands offered while busy are not accepted and are not queued; `cmd_ready`=0.
- `wdata_valid` outside WR is ignored; `wdata_ready`=0.
- Reads and writes never overlap; the block is strictly one burst at a time.
- Read-data tracking: an issue-valid/last shift pipe of depth RD_LAT+1 drives `rdata_valid` and `rdata_last`, aligned to `ram_q`.

## Timing
- Reset (`rst_n` low, asynchronous) values:
  - state = IDLE;
  - `cmd_ready`=1 combinationally (no command is accepted while `rst_n` is low);
  - `wdata_ready`, `ram_wr_en`, `rdata_valid`, `rdata_last`, `done`, `busy` = 0;
  - `ram_addr`, `ram_data` = 0;
  - the read pipe is cleared.
- Reset mid-burst: the burst aborts and `ram_wr_en` drops immediately. In-flight reads produce no `rdata_valid`, and no `done` is generated.
- Write latency: a beat accepted at edge E is written by the RAM at edge E+1.
- Read latency: for a command accepted at edge E0, beat k appears as `rdata_valid` in the cycle after edge E0+1+k+RD_LAT. With RD_LAT=1, beat 0 is valid between edges E0+2 and E0+3.
- Throughput:
  - a gapless N-beat write occupies N cycles in WR;
  - an N-beat read returns N consecutive valid beats;
  - `cmd_ready` rises the cycle after `done`.

## Structure
- Package `ram_ctrl_pkg` holds:
  - `ADDR_W`, `DATA_W` and `LEN_W` defaults;
  - the state enum `ram_ctrl_state_t` {IDLE, WR, RD, RD_DRAIN};
  - the address-wrap increment helper.
- Sub-module `rd_lat_pipe`: a parameterised (RD_LAT+1) shift register carrying {valid, last}, with asynchronous active-low clear.

## Test plan
- After reset, read burst `cmd_addr`=0x00, `cmd_len`=3 → `rdata` = 0x048, 0x001, 0x050, 0x000 on consecutive cycles; `rdata_last` and `done` on the 4th beat.
- Write burst at 0x7E, `cmd_len`=3, data 0x1A5, 0x0F0, 0x123, 0x055 → `ram_addr` sequence 0x7E, 0x7F, 0x00, 0x01. A read at 0x7E, `cmd_len`=3, returns the same four words.
- Write burst at 0x20, `cmd_len`=1, with `wdata_valid` low for 3 cycles between beats → exactly two `ram_wr_en` cycles and `done` on the second. Reading 0x20–0x21 returns the data.
- `cmd_valid` held high with a different command during an active 16-beat read → `cmd_ready` stays 0 for the whole burst. The second command is accepted only the cycle after `done`.
- Assert `rst_n` low after beat 2 of a 16-beat write at 0x30 → `ram_wr_en` drops immediately and no `done` pulse occurs. After release, `cmd_ready`=1, and reading 0x09 returns 0x1FF (the init image is restored).

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared widths, FSM state type and address arithmetic for the RAM burst front-end.
package ram_ctrl_pkg;

    localparam int RAM_ADDR_W  = 7;
    localparam int RAM_DATA_W  = 9;
    localparam int BURST_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD       = 2'd2,
        RD_DRAIN = 2'd3
    } ram_ctrl_state_t;

    // Next address, wrapping modulo 2^width so a burst can cross the top of the RAM.
    function automatic logic [31:0] addr_wrap_inc(input logic [31:0] addr, input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (addr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Shift pipe carrying {valid, last} for issued read addresses so they line up with ram_q.
module rd_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    input  logic             i_last,
    output logic [DEPTH-1:0] o_vld,
    output logic [DEPTH-1:0] o_last
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            r_vld  <= {r_vld[DEPTH-2:0], i_vld};
            r_last <= {r_last[DEPTH-2:0], i_last};
        end
    end

    assign o_vld  = r_vld;
    assign o_last = r_last;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Single-burst command front-end driving a single-port RAM: streams write beats to
// consecutive addresses and returns read beats in order with a last marker.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = BURST_LEN_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_q
);

    ram_ctrl_state_t   r_state;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wr_en;
    logic              r_done;

    logic              w_cmd_fire;
    logic              w_issue;
    logic              w_issue_last;
    logic [RD_LAT:0]   w_pipe_vld;
    logic [RD_LAT:0]   w_pipe_last;
    logic [ADDR_W-1:0] w_addr_next;

    // done is masked in so cmd_ready only rises the cycle after a burst completes.
    assign cmd_ready    = (r_state == IDLE) && !r_done;
    assign wdata_ready  = (r_state == WR);
    assign busy         = (r_state != IDLE);
    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_issue      = (r_state == RD);
    assign w_issue_last = w_issue && (r_beat_cnt == '0);
    assign w_addr_next  = ADDR_W'(addr_wrap_inc(32'(r_addr_cnt), ADDR_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_wr_en <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_ram_wr_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_addr_cnt <= cmd_addr;
                        r_beat_cnt <= cmd_len;
                        r_state    <= cmd_write ? WR : RD;
                    end
                end
                WR: begin
                    if (wdata_valid) begin
                        r_ram_addr  <= r_addr_cnt;
                        r_ram_data  <= wdata;
                        r_ram_wr_en <= 1'b1;
                        r_addr_cnt  <= w_addr_next;
                        r_beat_cnt  <= r_beat_cnt - LEN_W'(1);
                        if (r_beat_cnt == '0) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    r_ram_addr <= r_addr_cnt;
                    r_addr_cnt <= w_addr_next;
                    r_beat_cnt <= r_beat_cnt - LEN_W'(1);
                    if (r_beat_cnt == '0) begin
                        r_state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    // Register done one stage early so it lands with rdata_last.
                    if (w_pipe_vld[RD_LAT-1] && w_pipe_last[RD_LAT-1]) begin
                        r_done <= 1'b1;
                    end
                    if (w_pipe_vld[RD_LAT] && w_pipe_last[RD_LAT]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    rd_lat_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_rd_lat_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (w_issue),
        .i_last (w_issue_last),
        .o_vld  (w_pipe_vld),
        .o_last (w_pipe_last)
    );

    assign ram_addr    = r_ram_addr;
    assign ram_data    = r_ram_data;
    assign ram_wr_en   = r_ram_wr_en;
    assign done        = r_done;
    assign rdata       = ram_q;
    assign rdata_valid = w_pipe_vld[RD_LAT];
    assign rdata_last  = w_pipe_vld[RD_LAT] && w_pipe_last[RD_LAT];

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 128x9 RAM (init image reloaded on reset).
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [6:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wdata_valid, wdata_ready;
    logic [8:0] wdata;
    logic       rdata_valid, rdata_last, done, busy;
    logic [8:0] rdata;
    logic [6:0] ram_addr;
    logic [8:0] ram_data;
    logic       ram_wr_en;
    logic [8:0] ram_q;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] mem    [128];
    logic [8:0] shadow [128];

    always #5 clk = ~clk;

    ram_burst_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .done        (done),
        .busy        (busy),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_wr_en   (ram_wr_en),
        .ram_q       (ram_q)
    );

    function automatic logic [8:0] init_word(input int a);
        case (a)
            0:       return 9'h048;
            1:       return 9'h001;
            2:       return 9'h050;
            3:       return 9'h000;
            9:       return 9'h1FF;
            default: return 9'(a);
        endcase
    endfunction

    // RAM model: one-cycle registered read, write at the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            ram_q <= 9'h000;
        end else begin
            if (ram_wr_en) mem[ram_addr] <= ram_data;
            ram_q <= mem[ram_addr];
        end
    end

    task automatic shadow_reset();
        for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       cv;
        logic       cw;
        logic [6:0] ca;
        logic [3:0] cl;
        logic       wv;
        logic [8:0] wd;
        logic       e_rdy;
        logic       e_wrdy;
        logic       e_busy;
        logic       e_done;
        logic       e_we;
        logic [6:0] e_ra;
        logic [8:0] e_rd;
        logic       e_rv;
        logic       e_rl;
        logic [8:0] e_q;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t V(input logic cv, input logic cw, input logic [6:0] ca,
                               input logic [3:0] cl, input logic wv, input logic [8:0] wd,
                               input logic rdy, input logic wrdy, input logic bsy, input logic dn,
                               input logic we, input logic [6:0] ra, input logic [8:0] rd,
                               input logic rv, input logic rl, input logic [8:0] q);
        vec_t v;
        v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd;
        v.e_rdy = rdy; v.e_wrdy = wrdy; v.e_busy = bsy; v.e_done = dn; v.e_we = we;
        v.e_ra = ra; v.e_rd = rd; v.e_rv = rv; v.e_rl = rl; v.e_q = q;
        return v;
    endfunction

    task automatic do_read(input logic [6:0] a, input logic [3:0] l, input string tag);
        int n, gaps, dmis;
        logic started, fin;
        logic [8:0] got [16];
        n = 0; gaps = 0; dmis = 0; started = 1'b0; fin = 1'b0;
        for (int k = 0; k < 16; k++) got[k] = 9'h000;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (rdata_valid === 1'b1) begin
                if (n < 16) got[n] = rdata;
                if (done !== rdata_last) dmis++;
                if (rdata_last === 1'b1) fin = 1'b1;
                n++;
                started = 1'b1;
            end else begin
                if (started) gaps++;
                if (done === 1'b1) dmis++;
            end
            tick();
        end
        chk({tag, "_complete"}, 32'(fin), 32'd1);
        chk({tag, "_beats"}, n, 32'(l) + 32'd1);
        chk({tag, "_gaps"}, gaps, 0);
        chk({tag, "_done_vs_last"}, dmis, 0);
        for (int k = 0; k <= int'(l); k++)
            chk($sformatf("%s_beat%0d", tag, k), 32'(got[k]), 32'(shadow[7'(32'(a) + k)]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_n, done_n, done_we, bubble_rdy, n, rdy_hi, dn;
        logic fin;
        logic [6:0] a0, a1;
        logic [8:0] d0, d1;
        logic [8:0] gotb [16];

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        shadow_reset();
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int k = 0; k < 16; k++) gotb[k] = '0;

        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_wdata_ready", 32'(wdata_ready), 0);
        chk("rst_wr_en", 32'(ram_wr_en), 0);
        chk("rst_rdata_valid", 32'(rdata_valid), 0);
        chk("rst_rdata_last", 32'(rdata_last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_data", 32'(ram_data), 0);
        #10 rst_n = 1'b1;
        tick();

        // Cycle table: read 0x00 x4, wrapping write at 0x7E x4, read-back at 0x7E x4.
        //               cv cw ca     cl    wv wd       rdy wrdy bsy dn we ra     rd       rv rl q
        vq.push_back(V(1, 0, 7'h00, 4'd3, 0, 9'h000,   1, 0, 0, 0, 0, 7'h00, 9'h000,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h00, 9'h000,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h00, 9'h000,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h01, 9'h000,   1, 0, 9'h048));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h02, 9'h000,   1, 0, 9'h001));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h03, 9'h000,   1, 0, 9'h050));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 1, 0, 7'h03, 9'h000,   1, 1, 9'h000));
        vq.push_back(V(1, 1, 7'h7E, 4'd3, 1, 9'h1A5,   1, 0, 0, 0, 0, 7'h03, 9'h000,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 1, 9'h1A5,   0, 1, 1, 0, 0, 7'h03, 9'h000,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 1, 9'h0F0,   0, 1, 1, 0, 1, 7'h7E, 9'h1A5,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 1, 9'h123,   0, 1, 1, 0, 1, 7'h7F, 9'h0F0,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 1, 9'h055,   0, 1, 1, 0, 1, 7'h00, 9'h123,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 0, 1, 1, 7'h01, 9'h055,   0, 0, 9'h000));
        vq.push_back(V(1, 0, 7'h7E, 4'd3, 0, 9'h000,   1, 0, 0, 0, 0, 7'h01, 9'h055,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h01, 9'h055,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h7E, 9'h055,   0, 0, 9'h000));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h7F, 9'h055,   1, 0, 9'h1A5));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h00, 9'h055,   1, 0, 9'h0F0));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 0, 0, 7'h01, 9'h055,   1, 0, 9'h123));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   0, 0, 1, 1, 0, 7'h01, 9'h055,   1, 1, 9'h055));
        vq.push_back(V(0, 0, 7'h00, 4'd0, 0, 9'h000,   1, 0, 0, 0, 0, 7'h01, 9'h055,   0, 0, 9'h000));

        foreach (vq[i]) begin
            chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vq[i].e_rdy));
            chk($sformatf("v%0d_wdata_ready", i), 32'(wdata_ready), 32'(vq[i].e_wrdy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vq[i].e_done));
            chk($sformatf("v%0d_wr_en", i), 32'(ram_wr_en), 32'(vq[i].e_we));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vq[i].e_ra));
            chk($sformatf("v%0d_ram_data", i), 32'(ram_data), 32'(vq[i].e_rd));
            chk($sformatf("v%0d_rdata_valid", i), 32'(rdata_valid), 32'(vq[i].e_rv));
            chk($sformatf("v%0d_rdata_last", i), 32'(rdata_last), 32'(vq[i].e_rl));
            if (vq[i].e_rv) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vq[i].e_q));
            cmd_valid = vq[i].cv; cmd_write = vq[i].cw; cmd_addr = vq[i].ca; cmd_len = vq[i].cl;
            wdata_valid = vq[i].wv; wdata = vq[i].wd;
            tick();
        end
        shadow[7'h7E] = 9'h1A5; shadow[7'h7F] = 9'h0F0; shadow[7'h00] = 9'h123; shadow[7'h01] = 9'h055;

        // Two-beat write at 0x20 with a three-cycle bubble between beats.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h20; cmd_len = 4'd1;
        tick();
        cmd_valid = 1'b0;
        we_n = 0; done_n = 0; done_we = 0; bubble_rdy = 0;
        for (int c = 0; c < 10; c++) begin
            wdata_valid = (c == 0 || c == 4);
            wdata = (c == 0) ? 9'h0AA : 9'h155;
            tick();
            wdata_valid = 1'b0;
            if (ram_wr_en === 1'b1) begin
                we_n++;
                if (we_n == 1) begin a0 = ram_addr; d0 = ram_data; end
                else begin a1 = ram_addr; d1 = ram_data; end
            end
            if (done === 1'b1) begin
                done_n++;
                if (ram_wr_en === 1'b1 && we_n == 2) done_we++;
            end
            if (c >= 1 && c <= 3 && wdata_ready === 1'b1) bubble_rdy++;
        end
        chk("bub_wr_en_cycles", we_n, 2);
        chk("bub_done_pulses", done_n, 1);
        chk("bub_done_on_2nd", done_we, 1);
        chk("bub_ready_held", bubble_rdy, 3);
        chk("bub_addr0", 32'(a0), 32'h20);
        chk("bub_data0", 32'(d0), 32'h0AA);
        chk("bub_addr1", 32'(a1), 32'h21);
        chk("bub_data1", 32'(d1), 32'h155);
        shadow[7'h20] = 9'h0AA; shadow[7'h21] = 9'h155;
        do_read(7'h20, 4'd1, "rdA");

        // 16-beat read while a different command is held on the command port.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h00; cmd_len = 4'd15;
        tick();
        cmd_write = 1'b1; cmd_addr = 7'h40; cmd_len = 4'd0;
        n = 0; rdy_hi = 0; fin = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            if (cmd_ready === 1'b1) rdy_hi++;
            if (rdata_valid === 1'b1) begin
                if (n < 16) gotb[n] = rdata;
                n++;
            end
            if (done === 1'b1) fin = 1'b1;
            else tick();
        end
        chk("held_done_seen", 32'(fin), 1);
        chk("held_ready_low", rdy_hi, 0);
        chk("held_beats", n, 16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("held_beat%0d", k), 32'(gotb[k]), 32'(shadow[k]));
        tick();
        chk("held_ready_after_done", 32'(cmd_ready), 1);
        chk("held_busy_after_done", 32'(busy), 0);
        tick();
        cmd_valid = 1'b0;
        chk("held_2nd_accepted", 32'(wdata_ready), 1);
        chk("held_2nd_busy", 32'(busy), 1);
        wdata_valid = 1'b1; wdata = 9'h1C3;
        tick();
        wdata_valid = 1'b0;
        chk("held_2nd_wr_en", 32'(ram_wr_en), 1);
        chk("held_2nd_addr", 32'(ram_addr), 32'h40);
        chk("held_2nd_data", 32'(ram_data), 32'h1C3);
        chk("held_2nd_done", 32'(done), 1);
        shadow[7'h40] = 9'h1C3;
        tick();

        // Reset during a 16-beat write at 0x30, just after beat 2 is on the RAM port.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h30; cmd_len = 4'd15;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wdata_valid = 1'b1; wdata = 9'(9'h100 + k);
            tick();
        end
        chk("rstw_beat2_wr_en", 32'(ram_wr_en), 1);
        chk("rstw_beat2_addr", 32'(ram_addr), 32'h32);
        wdata_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_wr_en_drop", 32'(ram_wr_en), 0);
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_done", 32'(done), 0);
        chk("rstw_cmd_ready", 32'(cmd_ready), 1);
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ram_wr_en !== 1'b0) dn++;
        end
        #2 rst_n = 1'b1;
        tick();
        if (done !== 1'b0 || rdata_valid !== 1'b0) dn++;
        chk("rstw_no_done_or_wr", dn, 0);
        chk("rstw_ready_after", 32'(cmd_ready), 1);
        chk("rstw_busy_after", 32'(busy), 0);
        shadow_reset();
        do_read(7'h09, 4'd0, "rdC09");
        do_read(7'h30, 4'd0, "rdC30");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
